mat_sched_l7: RTL and testbench
===============================

// Module: mat_sched_l7
// PURPOSE
//  Sequencer for the layer-7 16x16 multiply/adder-tree array. On start it walks every output
//  channel group, output pixel and input channel group, and issues the matching addresses for
//  the feature BRAM, weight ROM, bias ROM and skip BRAM. It also drives the load/accumulate
//  strobes and the mode word U, then raises the write strobe for the result BRAM once the
//  array pipeline has drained. One instance serves one array. There is no arbitration.
// PARAMETERS
//  N_PIX     196  output pixels per channel group (14x14 map)
//  N_CG      8    input channel groups of 16, accumulated per output word
//  N_OG      8    output channel groups of 16
//  PIPE_LAT  6    cycles from array input strobe to valid array output; must be >= 2
//  ADDR_W    12   width of all address ports; must hold N_OG*N_PIX-1 and N_PIX*N_CG-1
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       single-cycle run request; accepted only in IDLE
//  cfg_u      in   3       mode word; sampled at accepted start
//  busy       out  1       high from the cycle after accepted start until done
//  done       out  1       one-cycle pulse after the last write
//  in_addr    out  ADDR_W  feature BRAM read address = pix*N_CG + cg
//  w_addr     out  ADDR_W  weight ROM address = og*N_CG + cg
//  b_addr     out  ADDR_W  bias ROM address = og
//  skip_addr  out  ADDR_W  skip BRAM read address = og*N_PIX + pix
//  load       out  1       array load_sig: first group of an output word (bias + products)
//  acc_en     out  1       array accumulate strobe for groups 1..N_CG-1
//  U          out  3       registered cfg_u, held constant through the run
//  wr_en      out  1       result BRAM write enable
//  wr_addr    out  ADDR_W  result BRAM write address = og*N_PIX + pix
// BEHAVIOUR
//  - Reset: state=IDLE, all counters 0, and every output 0 (busy, done, load, acc_en, wr_en,
//    U and all addresses).
//  - FSM: IDLE -(start)-> RUN -(last address issued)-> DRAIN -(pipe empty)-> DONE -> IDLE.
//    DONE lasts 1 cycle; done=1 only in that cycle.
//  - Loop order: og outer, pix middle, cg inner. cg wraps N_CG-1 -> 0 and increments pix.
//    pix wraps N_PIX-1 -> 0 and increments og. RUN issues one address set per cycle, with
//    no bubbles, for exactly N_OG*N_PIX*N_CG cycles.
//  - Read latency is 1: load/acc_en are registered, so they align with the data of the
//    address issued the previous cycle. load=1 when cg==0, acc_en=1 when cg!=0; never both.
//  - Writeback: a PIPE_LAT-deep shift register carries {valid, og*N_PIX+pix}. It is tagged
//    valid on the strobe cycle where cg==N_CG-1 and emerges as wr_en/wr_addr exactly
//    PIPE_LAT cycles after that strobe. skip_addr leads wr_addr by 1 cycle (taken from
//    stage PIPE_LAT-1) so the skip operand reaches the array in time.
//  - DRAIN: no new addresses, load=acc_en=0, and the address ports hold their last values.
//    Exit when the shift register holds no valid bit.
//  - Total run = N_OG*N_PIX*N_CG + 1 + PIPE_LAT + 1 cycles from start to done.
//  - Write count is exactly N_OG*N_PIX. Each wr_addr appears once, in ascending order.
//  - start while busy or in DONE is ignored, and the run is not restarted. cfg_u changes
//    mid-run do not affect U.
//  - rst mid-run aborts immediately to the reset state. In-flight writes are discarded,
//    wr_en is 0 from the next cycle, and done is not pulsed.
//  - Degenerate case N_CG==1: every strobe is load, and every strobe tags a write.
// STRUCTURE
//  - Shared package/header l7_pkg: L7_N_PIX, L7_N_CG, L7_N_OG, L7_PIPE_LAT, L7_ADDR_W, and
//    the state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).
//  - Sub-module wb_delay_l7 (PARAMETERS DEPTH, W): shift register with valid bit, synchronous
//    clear on rst, tap outputs at DEPTH-1 and DEPTH. Counters, address arithmetic and the
//    FSM stay in this module.
// TESTING (bench with N_PIX=4, N_CG=3, N_OG=2, PIPE_LAT=5 unless noted)
//  1 reset: hold rst 3 cycles -> all outputs 0, and busy stays 0 with start=0.
//  2 full run, cfg_u=3'b101: start @t0 -> U=5 and busy=1 from t1. in_addr seq 0,1,2,3..11
//    then 0..11 again. w_addr 0,1,2 x4 then 3,4,5 x4. load/acc_en pattern L,A,A repeated
//    8 times. wr_en 8 pulses with wr_addr 0..7. done at t0+24+1+5+1. Total 8 writes.
//  3 timing: first wr_en exactly 5 cycles after the strobe of the 3rd group. skip_addr=0 one
//    cycle before wr_addr=0.
//  4 start asserted during RUN and again in the DONE cycle -> ignored. Exactly one done and
//    8 writes.
//  5 rst pulsed 1 cycle mid-DRAIN -> wr_en 0 next cycle, no done, and a new start runs a
//    full clean sequence.
//  6 N_CG=1, N_PIX=2, N_OG=1, PIPE_LAT=2 -> load on every strobe, acc_en never, and 2 writes
//    at addresses 0 and 1.

Source files
------------

// File: rtl/l7_pkg.sv
// Shared constants and state encoding for the layer-7 array sequencer.
package l7_pkg;

  localparam int L7_N_PIX    = 196;
  localparam int L7_N_CG     = 8;
  localparam int L7_N_OG     = 8;
  localparam int L7_PIPE_LAT = 6;
  localparam int L7_ADDR_W   = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } l7_state_e;

endpackage

// File: rtl/wb_delay_l7.sv
// Writeback delay line: carries {valid, result address} alongside the array pipeline.
// The DEPTH-1 tap feeds the skip BRAM one cycle ahead of the final write.
module wb_delay_l7 #(
  parameter int DEPTH = 6,
  parameter int W     = 12
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] tap_data_o,
  output logic         out_vld_o,
  output logic [W-1:0] out_data_o,
  output logic         pend_o
);

  logic [DEPTH:1] vld_q;
  logic [W-1:0]   data_q [DEPTH:1];

  // Shift valid and address one stage per cycle; rst clears in-flight writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 1; i <= DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q     <= {vld_q[DEPTH-1:1], vld_i};
      data_q[1] <= data_i;
      for (int i = 2; i <= DEPTH; i++) data_q[i] <= data_q[i-1];
    end
  end

  assign tap_data_o = data_q[DEPTH-1];
  assign out_vld_o  = vld_q[DEPTH];
  assign out_data_o = data_q[DEPTH];
  // Any write still travelling that has not reached the last stage.
  assign pend_o     = |vld_q[DEPTH-1:1];

endmodule

// File: rtl/mat_sched_l7.sv
// Layer-7 array sequencer: walks og/pix/cg, issues BRAM/ROM addresses, drives the
// load/accumulate strobes and emits result writes once the array pipeline drains.
module mat_sched_l7
  import l7_pkg::*;
#(
  parameter int N_PIX    = L7_N_PIX,
  parameter int N_CG     = L7_N_CG,
  parameter int N_OG     = L7_N_OG,
  parameter int PIPE_LAT = L7_PIPE_LAT,
  parameter int ADDR_W   = L7_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cfg_u,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] skip_addr,
  output logic              load,
  output logic              acc_en,
  output logic [2:0]        U,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] CG_MAX  = ADDR_W'(N_CG - 1);
  localparam logic [ADDR_W-1:0] PIX_MAX = ADDR_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] OG_MAX  = ADDR_W'(N_OG - 1);
  localparam logic [ADDR_W-1:0] NCG_A   = ADDR_W'(N_CG);
  localparam logic [ADDR_W-1:0] NPIX_A  = ADDR_W'(N_PIX);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  l7_state_e         state_q;
  logic [ADDR_W-1:0] og_q, pix_q, cg_q;
  logic [ADDR_W-1:0] og_d, pix_d, cg_d;
  logic              last_w;
  logic [ADDR_W-1:0] in_addr_q, w_addr_q, b_addr_q;
  logic              load_q, acc_q, busy_q, done_q;
  logic [2:0]        u_q;
  logic              tag_vld_q;
  logic [ADDR_W-1:0] tag_addr_q;
  logic              pend;

  // Next loop position: cg innermost, then pix, then og.
  always_comb begin
    cg_d   = cg_q;
    pix_d  = pix_q;
    og_d   = og_q;
    last_w = (cg_q == CG_MAX) && (pix_q == PIX_MAX) && (og_q == OG_MAX);
    if (cg_q == CG_MAX) begin
      cg_d = '0;
      if (pix_q == PIX_MAX) begin
        pix_d = '0;
        og_d  = og_q + ONE_A;
      end else begin
        pix_d = pix_q + ONE_A;
      end
    end else begin
      cg_d = cg_q + ONE_A;
    end
  end

  // Sequencer FSM with registered addresses, strobes and status.
  // Strobes and the write tag lag the address by one cycle to match BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      og_q       <= '0;
      pix_q      <= '0;
      cg_q       <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      load_q     <= 1'b0;
      acc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      u_q        <= '0;
      tag_vld_q  <= 1'b0;
      tag_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q    <= 1'b0;
          load_q    <= 1'b0;
          acc_q     <= 1'b0;
          tag_vld_q <= 1'b0;
          if (start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            u_q       <= cfg_u;
            og_q      <= '0;
            pix_q     <= '0;
            cg_q      <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            b_addr_q  <= '0;
          end
        end
        ST_RUN: begin
          load_q     <= (cg_q == '0);
          acc_q      <= (cg_q != '0);
          tag_vld_q  <= (cg_q == CG_MAX);
          tag_addr_q <= og_q * NPIX_A + pix_q;
          if (last_w) begin
            state_q <= ST_DRAIN;
          end else begin
            og_q      <= og_d;
            pix_q     <= pix_d;
            cg_q      <= cg_d;
            in_addr_q <= pix_d * NCG_A + cg_d;
            w_addr_q  <= og_d * NCG_A + cg_d;
            b_addr_q  <= og_d;
          end
        end
        ST_DRAIN: begin
          load_q    <= 1'b0;
          acc_q     <= 1'b0;
          tag_vld_q <= 1'b0;
          // Leave once nothing remains except possibly the write leaving this cycle.
          if (!tag_vld_q && !pend) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wb_delay_l7 #(
    .DEPTH (PIPE_LAT),
    .W     (ADDR_W)
  ) u_wb (
    .clk_i      (clk),
    .rst_i      (rst),
    .vld_i      (tag_vld_q),
    .data_i     (tag_addr_q),
    .tap_data_o (skip_addr),
    .out_vld_o  (wr_en),
    .out_data_o (wr_addr),
    .pend_o     (pend)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign in_addr = in_addr_q;
  assign w_addr  = w_addr_q;
  assign b_addr  = b_addr_q;
  assign load    = load_q;
  assign acc_en  = acc_q;
  assign U       = u_q;

endmodule

// File: tb/tb_mat_sched_l7.sv
// Bench for mat_sched_l7: a small configuration and the degenerate N_CG==1 case.
module tb_mat_sched_l7;

  localparam int AW  = 12;
  localparam int NP  = 4;
  localparam int NC  = 3;
  localparam int NO  = 2;
  localparam int PL  = 5;
  localparam int T   = NO * NP * NC;
  localparam int D   = T + PL + 2;
  localparam int DNP = 2;
  localparam int DNC = 1;
  localparam int DNO = 1;
  localparam int DPL = 2;
  localparam int DD  = DNO * DNP * DNC + DPL + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start_b;
  logic [2:0]    cfg_u;

  logic          a_busy, a_done, a_load, a_acc_en, a_wr_en;
  logic [AW-1:0] a_in_addr, a_w_addr, a_b_addr, a_skip_addr, a_wr_addr;
  logic [2:0]    a_U;
  logic          d_busy, d_done, d_load, d_acc_en, d_wr_en;
  logic [AW-1:0] d_in_addr, d_w_addr, d_b_addr, d_skip_addr, d_wr_addr;
  logic [2:0]    d_U;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_sched_l7 #(.N_PIX(NP), .N_CG(NC), .N_OG(NO), .PIPE_LAT(PL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_u(cfg_u),
    .busy(a_busy), .done(a_done), .in_addr(a_in_addr), .w_addr(a_w_addr),
    .b_addr(a_b_addr), .skip_addr(a_skip_addr), .load(a_load), .acc_en(a_acc_en),
    .U(a_U), .wr_en(a_wr_en), .wr_addr(a_wr_addr)
  );

  mat_sched_l7 #(.N_PIX(DNP), .N_CG(DNC), .N_OG(DNO), .PIPE_LAT(DPL), .ADDR_W(AW)) dut_d (
    .clk(clk), .rst(rst), .start(start_b), .cfg_u(cfg_u),
    .busy(d_busy), .done(d_done), .in_addr(d_in_addr), .w_addr(d_w_addr),
    .b_addr(d_b_addr), .skip_addr(d_skip_addr), .load(d_load), .acc_en(d_acc_en),
    .U(d_U), .wr_en(d_wr_en), .wr_addr(d_wr_addr)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_b = 1'b0; cfg_u = 3'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_load, a_acc_en, a_wr_en, a_U} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0", {a_busy, a_done, a_load, a_acc_en, a_wr_en, a_U});
    end
    checks++;
    if ({a_in_addr, a_w_addr, a_b_addr, a_skip_addr, a_wr_addr} !== '0) begin
      errors++;
      $display("FAIL reset_addr in=%0d w=%0d b=%0d sk=%0d wr=%0d exp=0",
               a_in_addr, a_w_addr, a_b_addr, a_skip_addr, a_wr_addr);
    end
    checks++;
    if ({d_busy, d_done, d_load, d_acc_en, d_wr_en, d_U} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl_d got=%b exp=0", {d_busy, d_done, d_load, d_acc_en, d_wr_en, d_U});
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({a_busy, a_done, a_wr_en} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle c=%0d busy/done/wr=%b exp=000", c, {a_busy, a_done, a_wr_en});
      end
    end
  endtask

  task automatic test_full_run();
    int nwr = 0;
    int last = -1;
    int k, kw, ks;
    logic eload, eacc, ewr;
    cfg_u = 3'b101; start = 1'b1;
    for (int c = 1; c <= D + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      k = (c <= T) ? c - 1 : T - 1;
      checks++;
      if (a_in_addr !== AW'(k % (NP * NC))) begin
        errors++; $display("FAIL full_in_addr c=%0d got=%0d exp=%0d", c, a_in_addr, k % (NP * NC));
      end
      checks++;
      if (a_w_addr !== AW'((k / (NP * NC)) * NC + k % NC)) begin
        errors++; $display("FAIL full_w_addr c=%0d got=%0d exp=%0d", c, a_w_addr, (k / (NP * NC)) * NC + k % NC);
      end
      checks++;
      if (a_b_addr !== AW'(k / (NP * NC))) begin
        errors++; $display("FAIL full_b_addr c=%0d got=%0d exp=%0d", c, a_b_addr, k / (NP * NC));
      end
      eload = (c >= 2) && (c <= T + 1) && ((c - 2) % NC == 0);
      eacc  = (c >= 2) && (c <= T + 1) && !eload;
      checks++;
      if ({a_load, a_acc_en} !== {eload, eacc}) begin
        errors++; $display("FAIL full_strobe c=%0d load/acc=%b exp=%b", c, {a_load, a_acc_en}, {eload, eacc});
      end
      kw  = c - 2 - PL;
      ewr = (kw >= 0) && (kw < T) && (kw % NC == NC - 1);
      checks++;
      if (a_wr_en !== ewr) begin
        errors++; $display("FAIL full_wr_en c=%0d got=%b exp=%b", c, a_wr_en, ewr);
      end
      if (ewr) begin
        checks++;
        if (a_wr_addr !== AW'(kw / NC)) begin
          errors++; $display("FAIL full_wr_addr c=%0d got=%0d exp=%0d", c, a_wr_addr, kw / NC);
        end
      end
      ks = kw + 1;
      if ((ks >= 0) && (ks < T) && (ks % NC == NC - 1)) begin
        checks++;
        if (a_skip_addr !== AW'(ks / NC)) begin
          errors++; $display("FAIL full_skip c=%0d got=%0d exp=%0d", c, a_skip_addr, ks / NC);
        end
      end
      checks++;
      if ({a_busy, a_done, a_U} !== {(c < D), (c == D), 3'b101}) begin
        errors++; $display("FAIL full_status c=%0d busy/done/U=%b exp=%b", c, {a_busy, a_done, a_U},
                           {(c < D), (c == D), 3'b101});
      end
      if (a_wr_en) begin
        nwr++;
        checks++;
        if (int'(a_wr_addr) <= last) begin
          errors++; $display("FAIL full_order c=%0d got=%0d prev=%0d", c, a_wr_addr, last);
        end
        last = int'(a_wr_addr);
      end
    end
    checks++;
    if (nwr != NO * NP) begin
      errors++; $display("FAIL full_wr_count got=%0d exp=%0d", nwr, NO * NP);
    end
  endtask

  task automatic test_timing();
    logic [2:0] cfg;
    logic [AW-1:0] prev_skip, sk_first, wa_first;
    int nstrobe = 0;
    int t3 = -1;
    int tw = -1;
    cfg = 3'($urandom); cfg_u = cfg; start = 1'b1;
    prev_skip = '1; sk_first = '1; wa_first = '1;
    for (int c = 1; c <= D + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_u = 3'($urandom);
      if (a_load || a_acc_en) begin
        nstrobe++;
        if (nstrobe == 3) t3 = c;
      end
      if (a_wr_en && tw < 0) begin
        tw = c; sk_first = prev_skip; wa_first = a_wr_addr;
      end
      prev_skip = a_skip_addr;
      checks++;
      if (a_load && a_acc_en) begin
        errors++; $display("FAIL timing_both_strobes c=%0d", c);
      end
      checks++;
      if (a_U !== cfg) begin
        errors++; $display("FAIL timing_U c=%0d got=%0d exp=%0d", c, a_U, cfg);
      end
    end
    checks++;
    if (t3 != 4) begin
      errors++; $display("FAIL timing_third_strobe got=%0d exp=4", t3);
    end
    checks++;
    if (tw < 0) begin
      errors++; $display("FAIL timing_first_wr timeout got=none exp=cycle %0d", 4 + PL);
    end else if (tw - t3 != PL) begin
      errors++; $display("FAIL timing_first_wr got=%0d exp=%0d", tw - t3, PL);
    end
    checks++;
    if (sk_first !== '0 || wa_first !== '0) begin
      errors++; $display("FAIL timing_skip_lead skip=%0d wr=%0d exp=0/0", sk_first, wa_first);
    end
  endtask

  task automatic test_ignored_start();
    logic [2:0] cfg;
    int ndone = 0;
    int nwr = 0;
    int last = -1;
    int rc;
    cfg = 3'($urandom); cfg_u = cfg; start = 1'b1;
    rc = int'($urandom_range(3, T + PL - 1));
    for (int c = 1; c <= D + 30; c++) begin
      @(negedge clk);
      start = (c == 3) || (c == 10) || (c == T) || (c == T + 3) || (c == rc) || (c == D);
      cfg_u = 3'($urandom);
      if (a_done) ndone++;
      if (a_wr_en) begin
        nwr++;
        checks++;
        if (int'(a_wr_addr) != last + 1) begin
          errors++; $display("FAIL ign_wr_seq c=%0d got=%0d exp=%0d", c, a_wr_addr, last + 1);
        end
        last = int'(a_wr_addr);
      end
      checks++;
      if (a_busy !== (c < D)) begin
        errors++; $display("FAIL ign_busy c=%0d got=%b exp=%b", c, a_busy, (c < D));
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL ign_done_count got=%0d exp=1", ndone);
    end
    checks++;
    if (nwr != NO * NP) begin
      errors++; $display("FAIL ign_wr_count got=%0d exp=%0d", nwr, NO * NP);
    end
    checks++;
    if (a_U !== cfg) begin
      errors++; $display("FAIL ign_U got=%0d exp=%0d", a_U, cfg);
    end
  endtask

  task automatic test_reset_drain();
    int nwr = 0;
    start = 1'b1;
    for (int c = 1; c <= T + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL rstd_busy_before got=%b exp=1", a_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_wr_en, a_busy, a_done, a_load, a_acc_en, a_U} !== 8'd0 || a_in_addr !== '0) begin
      errors++; $display("FAIL rstd_after wr/busy/done/ld/acc/U=%b in=%0d exp=0",
                         {a_wr_en, a_busy, a_done, a_load, a_acc_en, a_U}, a_in_addr);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if ({a_wr_en, a_done, a_busy} !== 3'b000) begin
        errors++; $display("FAIL rstd_quiet c=%0d wr/done/busy=%b exp=000", c, {a_wr_en, a_done, a_busy});
      end
    end
    cfg_u = 3'($urandom); start = 1'b1;
    for (int c = 1; c <= D + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c <= T) begin
        checks++;
        if (a_in_addr !== AW'((c - 1) % (NP * NC))) begin
          errors++; $display("FAIL rstd_in_addr c=%0d got=%0d exp=%0d", c, a_in_addr, (c - 1) % (NP * NC));
        end
      end
      if (a_wr_en) begin
        checks++;
        if (int'(a_wr_addr) != nwr) begin
          errors++; $display("FAIL rstd_wr_addr c=%0d got=%0d exp=%0d", c, a_wr_addr, nwr);
        end
        nwr++;
      end
      checks++;
      if (a_done !== (c == D)) begin
        errors++; $display("FAIL rstd_done c=%0d got=%b exp=%b", c, a_done, (c == D));
      end
    end
    checks++;
    if (nwr != NO * NP) begin
      errors++; $display("FAIL rstd_wr_count got=%0d exp=%0d", nwr, NO * NP);
    end
  endtask

  task automatic test_degenerate();
    logic [2:0] cfg;
    int nwr = 0;
    logic ewr;
    int k;
    cfg = 3'($urandom); cfg_u = cfg; start_b = 1'b1;
    for (int c = 1; c <= DD + 3; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      k = (c <= DNP) ? c - 1 : DNP - 1;
      checks++;
      if ({d_load, d_acc_en} !== {((c >= 2) && (c <= DNP + 1)), 1'b0}) begin
        errors++; $display("FAIL degen_strobe c=%0d load/acc=%b exp=%b", c, {d_load, d_acc_en},
                           {((c >= 2) && (c <= DNP + 1)), 1'b0});
      end
      checks++;
      if (d_in_addr !== AW'(k) || d_w_addr !== '0 || d_b_addr !== '0) begin
        errors++; $display("FAIL degen_addr c=%0d in=%0d w=%0d b=%0d exp=%0d/0/0", c, d_in_addr, d_w_addr, d_b_addr, k);
      end
      ewr = (c == 2 + DPL) || (c == 3 + DPL);
      checks++;
      if (d_wr_en !== ewr) begin
        errors++; $display("FAIL degen_wr_en c=%0d got=%b exp=%b", c, d_wr_en, ewr);
      end
      if (ewr) begin
        checks++;
        if (d_wr_addr !== AW'(c - 2 - DPL)) begin
          errors++; $display("FAIL degen_wr_addr c=%0d got=%0d exp=%0d", c, d_wr_addr, c - 2 - DPL);
        end
        nwr++;
      end
      if ((c == 1 + DPL) || (c == 2 + DPL)) begin
        checks++;
        if (d_skip_addr !== AW'(c - 1 - DPL)) begin
          errors++; $display("FAIL degen_skip c=%0d got=%0d exp=%0d", c, d_skip_addr, c - 1 - DPL);
        end
      end
      checks++;
      if ({d_busy, d_done, d_U} !== {(c < DD), (c == DD), cfg}) begin
        errors++; $display("FAIL degen_status c=%0d busy/done/U=%b exp=%b", c, {d_busy, d_done, d_U},
                           {(c < DD), (c == DD), cfg});
      end
    end
    checks++;
    if (nwr != DNO * DNP) begin
      errors++; $display("FAIL degen_wr_count got=%0d exp=%0d", nwr, DNO * DNP);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_timing();
    test_ignored_start();
    test_reset_drain();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
